// File: rtl/perceptron_predictor.sv
// perceptron_predictor: perceptron branch predictor with a speculative GHR, in-order commit training and mispredict GHR recovery.
module perceptron_predictor #(
    parameter int GHR_WIDTH     = 32,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int P_TABLE_SIZE  = 256,
    parameter int THETA         = 75
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    input  logic [31:0]                 req_pc,
    output logic                        resp_valid,
    output logic                        resp_taken,
    output logic signed [13:0]          resp_sum,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [31:0]                 upd_pc,
    input  logic                        upd_taken,
    input  logic                        upd_mispredict,
    output logic [GHR_WIDTH-1:0]        spec_ghr_o
);
    localparam int IW = $clog2(P_TABLE_SIZE);
    localparam int SW = 14;
    localparam logic signed [SW-1:0] TH = SW'(THETA);
    localparam logic signed [WEIGHTS_WIDTH-1:0] W_MAX = {1'b0, {(WEIGHTS_WIDTH-1){1'b1}}};
    localparam logic signed [WEIGHTS_WIDTH-1:0] W_MIN = {1'b1, {(WEIGHTS_WIDTH-1){1'b0}}};

    typedef logic [GHR_WIDTH:0][WEIGHTS_WIDTH-1:0] row_t;
    typedef enum logic {IDLE, TRAIN} state_t;

    row_t                    tbl [P_TABLE_SIZE];
    state_t                  state;
    logic [GHR_WIDTH-1:0]    spec_ghr, commit_ghr, t_hist;
    logic [IW-1:0]           t_idx;
    logic                    t_taken;
    logic                    accept, recover, do_train;
    logic signed [SW-1:0]    p_sum, t_sum;
    row_t                    t_row, new_row;
    logic                    unused;

    assign unused = ^{req_pc[31:IW+2], req_pc[1:0], upd_pc[31:IW+2], upd_pc[1:0]};

    function automatic logic signed [SW-1:0] ext(input logic [WEIGHTS_WIDTH-1:0] w);
        return {{(SW-WEIGHTS_WIDTH){w[WEIGHTS_WIDTH-1]}}, w};
    endfunction

    function automatic logic signed [SW-1:0] dot(input row_t row, input logic [GHR_WIDTH-1:0] h);
        logic signed [SW-1:0] s;
        s = ext(row[0]);
        for (int i = 0; i < GHR_WIDTH; i++)
            s = h[i] ? s + ext(row[i+1]) : s - ext(row[i+1]);
        return s;
    endfunction

    function automatic logic [WEIGHTS_WIDTH-1:0] sat(input logic signed [WEIGHTS_WIDTH-1:0] w, input logic up);
        return up ? (w == W_MAX ? w : w + 1'b1) : (w == W_MIN ? w : w - 1'b1);
    endfunction

    assign accept     = state == IDLE && upd_valid;
    assign recover    = accept && upd_mispredict;
    assign p_sum      = dot(tbl[req_pc[IW+1:2]], spec_ghr);
    assign t_row      = tbl[t_idx];
    assign t_sum      = dot(t_row, t_hist);
    assign do_train   = (!t_sum[SW-1] != t_taken) || (t_sum <= TH && t_sum >= -TH);
    assign spec_ghr_o = spec_ghr;

    // t*x_i is +1 exactly when the outcome agrees with that history bit
    always_comb begin
        new_row    = t_row;
        new_row[0] = sat(t_row[0], t_taken);
        for (int i = 0; i < GHR_WIDTH; i++)
            new_row[i+1] = sat(t_row[i+1], t_taken == t_hist[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int r = 0; r < P_TABLE_SIZE; r++) tbl[r] <= '0;
        else if (state == TRAIN && do_train)
            tbl[t_idx] <= new_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            upd_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            resp_sum   <= '0;
            spec_ghr   <= '0;
            commit_ghr <= '0;
            t_hist     <= '0;
            t_idx      <= '0;
            t_taken    <= 1'b0;
        end else begin
            resp_valid <= req_valid && !recover;
            if (req_valid && !recover) begin
                resp_sum   <= p_sum;
                resp_taken <= !p_sum[SW-1];
            end
            spec_ghr <= recover ? {commit_ghr[GHR_WIDTH-2:0], upd_taken} :
                        req_valid ? {spec_ghr[GHR_WIDTH-2:0], !p_sum[SW-1]} : spec_ghr;
            if (accept) begin
                commit_ghr <= {commit_ghr[GHR_WIDTH-2:0], upd_taken};
                t_hist     <= commit_ghr;
                t_idx      <= upd_pc[IW+1:2];
                t_taken    <= upd_taken;
                state      <= TRAIN;
                upd_ready  <= 1'b0;
            end else if (state == TRAIN) begin
                state     <= IDLE;
                upd_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_perceptron_predictor.sv
// tb_perceptron_predictor: scoreboard bench with an integer reference model of the weight table and both GHRs.
module tb_perceptron_predictor;
    logic clk = 0, rst_n = 0;
    logic req_valid = 0, upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
    logic [31:0] req_pc = 0, upd_pc = 0;
    logic resp_valid, resp_taken, upd_ready;
    logic signed [13:0] resp_sum;
    logic [31:0] spec_ghr_o;

    perceptron_predictor dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_sum(resp_sum),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict), .spec_ghr_o(spec_ghr_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit tk; int sum; logic [31:0] ghr; bit rdy; } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int w [256][33];
    logic [31:0] m_spec, m_commit, t_hist;
    int t_idx;
    bit t_tk, m_train;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int msum(input int r, input logic [31:0] h);
        int s = w[r][0];
        for (int i = 0; i < 32; i++) s += h[i] ? w[r][i+1] : -w[r][i+1];
        return s;
    endfunction

    function automatic int clamp(input int v);
        return v > 127 ? 127 : (v < -128 ? -128 : v);
    endfunction

    function automatic void model_clear();
        foreach (w[r, j]) w[r][j] = 0;
        m_spec = 0; m_commit = 0; t_hist = 0; t_idx = 0; t_tk = 0; m_train = 0;
    endfunction

    task automatic step(input bit rq, input logic [31:0] rpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input bit um);
        exp_t e, g;
        bit acc, rec;
        int s, ts, t;
        req_valid = rq; req_pc = rpc; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_mispredict = um;
        acc = uv && !m_train;
        rec = acc && um;
        s = msum((rpc >> 2) & 255, m_spec);
        e.v = rq && !rec; e.sum = s; e.tk = s >= 0;
        m_spec = rec ? {m_commit[30:0], ut} : rq ? {m_spec[30:0], s >= 0} : m_spec;
        if (m_train) begin
            ts = msum(t_idx, t_hist);
            t = t_tk ? 1 : -1;
            if (((ts >= 0) != t_tk) || (ts <= 75 && ts >= -75)) begin
                w[t_idx][0] = clamp(w[t_idx][0] + t);
                for (int i = 0; i < 32; i++)
                    w[t_idx][i+1] = clamp(w[t_idx][i+1] + (t_hist[i] ? t : -t));
            end
            m_train = 0;
        end else if (acc) begin
            t_idx = (upc >> 2) & 255; t_tk = ut; t_hist = m_commit;
            m_commit = {m_commit[30:0], ut};
            m_train = 1;
        end
        e.rdy = !m_train; e.ghr = m_spec;
        sb.push_back(e);
        @(posedge clk); #1;
        g = sb.pop_front();
        check("resp_valid", int'(resp_valid), int'(g.v));
        check("upd_ready", int'(upd_ready), int'(g.rdy));
        check("spec_ghr", int'(spec_ghr_o), int'(g.ghr));
        if (g.v) begin
            check("resp_sum", int'(resp_sum), g.sum);
            check("resp_taken", int'(resp_taken), int'(g.tk));
        end
        @(negedge clk);
        req_valid = 0; upd_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = 0; upd_valid = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        check("rst_valid", int'(resp_valid), 0);
        check("rst_sum", int'(resp_sum), 0);
        check("rst_ready", int'(upd_ready), 1);
        check("rst_ghr", int'(spec_ghr_o), 0);
    endtask

    initial begin
        do_reset();
        step(1, 32'h1000, 0, 0, 0, 0);
        check("first_sum", int'(resp_sum), 0);
        check("first_ghr", int'(spec_ghr_o), 1);

        // first training on row 0 from zero history, then a no-history request sees 1+32
        do_reset();
        step(0, 0, 1, 32'h1000, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h1000, 0, 0, 0, 0);
        check("trained_sum", int'(resp_sum), 33);

        // hold upd_valid high so half the cycles hit the busy predictor
        do_reset();
        for (int k = 0; k < 400; k++) step(0, 0, 1, 32'h1000, 1, 0);
        step(1, 32'h1000, 0, 0, 0, 0);
        step(1, 32'h1000, 0, 0, 0, 0);

        do_reset();
        step(1, 32'h1000, 0, 0, 0, 0);
        step(1, 32'h1000, 0, 0, 0, 0);
        step(1, 32'h1000, 0, 0, 0, 0);
        check("ghr_seq", int'(spec_ghr_o), 7);
        step(1, 32'h1000, 1, 32'h1000, 0, 1);
        check("recover_ghr", int'(spec_ghr_o), 0);
        check("recover_drop", int'(resp_valid), 0);

        // collision: request in the TRAIN cycle sees old weights
        do_reset();
        step(0, 0, 1, 32'h1000, 1, 0);
        step(1, 32'h1000, 0, 0, 0, 0);
        check("coll_old", int'(resp_sum), 0);
        step(1, 32'h1000, 0, 0, 0, 0);
        check("coll_new", int'(resp_sum), 31);

        // async reset while TRAIN is pending
        do_reset();
        step(1, 32'h1000, 1, 32'h1000, 1, 0);
        #1 rst_n = 0;
        #1;
        check("async_valid", int'(resp_valid), 0);
        check("async_sum", int'(resp_sum), 0);
        check("async_ready", int'(upd_ready), 1);
        check("async_ghr", int'(spec_ghr_o), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h1000, 0, 0, 0, 0);
        check("async_row0", int'(resp_sum), 0);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] pcs [4];
            pcs[0] = 32'h1000; pcs[1] = 32'h1004; pcs[2] = 32'h1400; pcs[3] = 32'h2008;
            step($urandom_range(0, 1), pcs[$urandom_range(0, 3)], $urandom_range(0, 1),
                 pcs[$urandom_range(0, 3)], $urandom_range(0, 1), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
